// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared types and constants for the sequential shift-and-add
//                multiplier: FSM state encoding, default operand width and a
//                ceiling-log2 helper used to size the iteration counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Smallest r such that 2**r >= value (returns 1 for value <= 2).
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder
//  Description : Single-bit full adder cell.
//  Ports       : a, b  - addend bits
//                cin   - carry in
//                s     - sum bit
//                cout  - carry out
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule
`default_nettype wire

// File: rtl/half_adder.sv
`default_nettype none
// ============================================================================
//  Module      : half_adder
//  Description : Single-bit half adder cell.
//  Ports       : a, b  - addend bits
//                s     - sum bit
//                c     - carry out
//  Revision    : 1.0 - initial release
// ============================================================================
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule
`default_nettype wire

// File: rtl/rca_adder.sv
`default_nettype none
// ============================================================================
//  Module      : rca_adder
//  Description : N-bit combinational ripple-carry adder. Bit 0 is a half
//                adder (no carry in); bits 1..N-1 are full adders.
//  Ports       : x, y  - N-bit addends
//                s     - N-bit sum
//                cout  - carry out of the MSB
//  Revision    : 1.0 - initial release
// ============================================================================
module rca_adder
  import mult_pkg::*;
#(
  parameter int N = 2 * DEFAULT_WIDTH
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] s,
  output logic         cout
);

  // w_carry[i] is the carry out of bit i.
  logic [N-1:0] w_carry;

  half_adder u_ha (
    .a (x[0]),
    .b (y[0]),
    .s (s[0]),
    .c (w_carry[0])
  );

  for (genvar i = 1; i < N; i++) begin : g_fa
    full_adder u_fa (
      .a    (x[i]),
      .b    (y[i]),
      .cin  (w_carry[i-1]),
      .s    (s[i]),
      .cout (w_carry[i])
    );
  end

  assign cout = w_carry[N-1];

endmodule
`default_nettype wire

// File: rtl/seq_shift_add_mult.sv
`default_nettype none
// ============================================================================
//  Module      : seq_shift_add_mult
//  Description : Sequential unsigned shift-and-add multiplier. One partial
//                product row is added per clock through a single ripple-carry
//                adder; operands and product use valid/ready handshakes.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                in_valid/in_ready   - operand handshake
//                a, b                - WIDTH-bit multiplicand / multiplier
//                out_valid/out_ready - product handshake
//                product             - 2*WIDTH-bit result
//                busy                - high while iterating
//  Options     : SEQ_MULT_EARLY_TERM_EN - finish as soon as the remaining
//                multiplier bits are all zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  // One extra count of headroom so the counter never wraps when early
  // termination lets RUN last WIDTH+1 cycles.
  localparam int CW = clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
`ifndef SEQ_MULT_EARLY_TERM_EN
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
`endif

  state_t           r_state;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_mcand_sh;
  logic [WIDTH-1:0] r_mplier_sh;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_product;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [PW-1:0]    w_addend;
  logic [PW-1:0]    w_sum;
  logic             w_cout_unused;  // acc + mcand_sh always fits in PW bits

  assign w_addend = r_mplier_sh[0] ? r_mcand_sh : '0;

  rca_adder #(.N(PW)) u_rca (
    .x    (r_acc),
    .y    (w_addend),
    .s    (w_sum),
    .cout (w_cout_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_mcand_sh  <= '0;
      r_mplier_sh <= '0;
      r_cnt       <= '0;
      r_product   <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mcand_sh  <= {{WIDTH{1'b0}}, a};
            r_mplier_sh <= b;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_state     <= RUN;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b1;
          end
        end

        RUN: begin
`ifdef SEQ_MULT_EARLY_TERM_EN
          // Remaining multiplier bits all zero: acc already holds the answer.
          if (r_mplier_sh == '0) begin
            r_product   <= r_acc;
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end else begin
            r_acc       <= w_sum;
            r_mcand_sh  <= r_mcand_sh << 1;
            r_mplier_sh <= r_mplier_sh >> 1;
            r_cnt       <= r_cnt + CNT_ONE;
          end
`else
          r_acc       <= w_sum;
          r_mcand_sh  <= r_mcand_sh << 1;
          r_mplier_sh <= r_mplier_sh >> 1;
          r_cnt       <= r_cnt + CNT_ONE;
          // Last iteration: capture the sum including this row directly.
          if (r_cnt == CNT_LAST) begin
            r_product   <= w_sum;
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end
`endif
        end

        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign product   = r_product;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_seq_shift_add_mult.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_shift_add_mult
//  Description : Self-checking bench for seq_shift_add_mult (WIDTH=8).
//                Directed vector table, backpressure, mid-operation reset and
//                randomized back-to-back traffic against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_shift_add_mult;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int n_checks;
  int n_errors;

  seq_shift_add_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic product and latency rule.
  function automatic logic [31:0] ref_product(input logic [W-1:0] x, input logic [W-1:0] y);
    return 32'(x) * 32'(y);
  endfunction

  function automatic int ref_latency(input logic [W-1:0] y);
`ifdef SEQ_MULT_EARLY_TERM_EN
    int msb;
    if (y == 0) return 1;
    msb = 0;
    for (int i = 0; i < W; i++) if (y[i]) msb = i;
    return msb + 2;
`else
    return W;
`endif
  endfunction

  // Handshake-compliance monitor: the two ready/valid outputs never overlap.
  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if (out_valid && in_ready) begin
        n_errors++;
        $display("FAIL excl: out_valid=%0b in_ready=%0b both high", out_valid, in_ready);
      end
    end
  end

  // Presents operands (called ~1ns after an edge), waits for the accept
  // edge, then counts edges until out_valid. Leaves in_valid high if asked.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input bit keep_valid, output int lat);
    int guard;
    bit busy_ok;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    a = ta; b = tb_v; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = keep_valid;
    a = W'($urandom); b = W'($urandom);  // must be ignored while busy
    lat = 0;
    busy_ok = 1'b1;
    while (!out_valid && lat < 200) begin
      if (!busy || in_ready) busy_ok = 1'b0;
      @(posedge clk); #1; lat++;
    end
    check("run_busy", 32'(busy_ok), 32'd1);
    check("out_valid_seen", 32'(out_valid), 32'd1);
  endtask

  // Completes the output handshake (out_ready assumed already high).
  task automatic finish_op;
    @(posedge clk); #1;
    check("post_hs_out_valid", 32'(out_valid), 32'd0);
    check("post_hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  typedef struct {
    logic [W-1:0]   va;
    logic [W-1:0]   vb;
    logic [2*W-1:0] exp_p;
    int             lat_fixed;
    int             lat_early;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat;
    int exp_lat;
    logic [2*W-1:0] held;

    vecs[0] = '{8'd13,  8'd11,  16'd143,   8, 5};
    vecs[1] = '{8'd255, 8'd255, 16'd65025, 8, 9};
    vecs[2] = '{8'd0,   8'd200, 16'd0,     8, 9};
    vecs[3] = '{8'd200, 8'd3,   16'd600,   8, 3};
    vecs[4] = '{8'd77,  8'd0,   16'd0,     8, 1};
    vecs[5] = '{8'd1,   8'd128, 16'd128,   8, 9};
    vecs[6] = '{8'd5,   8'd6,   16'd30,    8, 4};

    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    in_valid = 1'b1;   // asserted during reset: must be ignored
    a = 8'd9; b = 8'd9;
    out_ready = 1'b1;

    // Reset state, with in_valid high throughout.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy", 32'(busy), 32'd0);

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
`ifdef SEQ_MULT_EARLY_TERM_EN
      exp_lat = vecs[i].lat_early;
`else
      exp_lat = vecs[i].lat_fixed;
`endif
      start_op(vecs[i].va, vecs[i].vb, 1'b0, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat));
      check($sformatf("vec%0d_product", i), 32'(product), 32'(vecs[i].exp_p));
      check($sformatf("vec%0d_in_ready_done", i), 32'(in_ready), 32'd0);
      finish_op();
    end

    // Backpressure: DONE held with a stable product.
    out_ready = 1'b0;
    start_op(8'd7, 8'd9, 1'b0, lat);
    check("bp_latency", 32'(lat), 32'(ref_latency(8'd9)));
    held = product;
    check("bp_product", 32'(held), 32'd63);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || product !== held)
        check($sformatf("bp_hold_c%0d", i), {out_valid, in_ready, 14'd0, product},
              {1'b1, 1'b0, 14'd0, held});
      else n_checks++;
    end
    out_ready = 1'b1;
    finish_op();

    // Reset in the middle of RUN.
    start_op(8'd100, 8'd0, 1'b0, lat);  // warm-up op leaves product at 0
    finish_op();
    a = 8'd100; b = 8'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_product", 32'(product), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_op(8'd5, 8'd6, 1'b0, lat);
    check("midrst_after_product", 32'(product), 32'd30);
    check("midrst_after_latency", 32'(lat), 32'(ref_latency(8'd6)));
    finish_op();

    // Back-to-back random traffic, in_valid held high.
    for (int i = 0; i < 50; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = (i % 5 == 0) ? W'($urandom_range(0, 7)) : W'($urandom);
      start_op(ra, rb, 1'b1, lat);
      check($sformatf("rnd%0d_product a=%0d b=%0d", i, ra, rb), 32'(product), ref_product(ra, rb));
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(ref_latency(rb)));
      finish_op();
    end
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
